// File: rtl/uart_ad_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_ad_rx
// Brief    : UART receiver and "ADn:+d.ddddV" frame parser with BCD outputs.
//            Optional even parity via macro UART_AD_RX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_ad_rx #(
    parameter int BAUD_DIV = 325
) (
    input  logic        clk50,
    input  logic        reset_n,
    input  logic        rx,
    output logic [2:0]  ch_num,
    output logic [7:0]  ch_sig,
    output logic [19:0] ch_dec,
    output logic        frame_valid,
    output logic        frame_err
);

    localparam int              c_BW       = $clog2(BAUD_DIV + 1);
    localparam logic [c_BW-1:0] c_BAUD_MAX = c_BW'(BAUD_DIV - 1);

    localparam logic [2:0] c_RX_IDLE   = 3'd0;
    localparam logic [2:0] c_RX_START  = 3'd1;
    localparam logic [2:0] c_RX_DATA   = 3'd2;
    localparam logic [2:0] c_RX_PARITY = 3'd3;
    localparam logic [2:0] c_RX_STOP   = 3'd4;

    // Parser states are named after the byte they expect next.
    localparam logic [3:0] c_P_A     = 4'd0;
    localparam logic [3:0] c_P_D     = 4'd1;
    localparam logic [3:0] c_P_CH    = 4'd2;
    localparam logic [3:0] c_P_COLON = 4'd3;
    localparam logic [3:0] c_P_SIGN  = 4'd4;
    localparam logic [3:0] c_P_UNIT  = 4'd5;
    localparam logic [3:0] c_P_DOT   = 4'd6;
    localparam logic [3:0] c_P_F0    = 4'd7;
    localparam logic [3:0] c_P_F1    = 4'd8;
    localparam logic [3:0] c_P_F2    = 4'd9;
    localparam logic [3:0] c_P_F3    = 4'd10;
    localparam logic [3:0] c_P_V     = 4'd11;

    logic            r_rx_meta, r_rx_sync, r_rx_prev;
    logic [c_BW-1:0] r_baud_cnt;
    logic            r_tick;
    logic [2:0]      r_rx_state, w_rx_next;
    logic [3:0]      r_os_cnt;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic            w_rx_fall, w_half_end, w_bit_end, w_sample;
    logic            w_byte_stb, w_rx_err;
    logic [3:0]      r_p_state, w_p_next;
    logic            w_match, w_is_digit, w_accept, w_p_err;
    logic [3:0]      w_digit;
    logic [2:0]      w_chan;
    logic [2:0]      r_stg_num;
    logic [7:0]      r_stg_sig;
    logic [19:0]     r_stg_dec;

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_baud_cnt <= '0;
            r_tick     <= 1'b0;
        end else begin
            r_rx_meta  <= rx;
            r_rx_sync  <= r_rx_meta;
            r_rx_prev  <= r_rx_sync;
            r_tick     <= (r_baud_cnt == c_BAUD_MAX);
            r_baud_cnt <= (r_baud_cnt == c_BAUD_MAX) ? '0 : r_baud_cnt + 1'b1;
        end
    end

    assign w_rx_fall  = r_rx_prev & ~r_rx_sync;
    assign w_half_end = r_tick & (r_os_cnt == 4'd7);
    assign w_bit_end  = r_tick & (r_os_cnt == 4'd15);
    assign w_sample   = (r_rx_state == c_RX_DATA) & w_bit_end;

    // ---------------- byte receiver FSM ----------------
    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) r_rx_state <= c_RX_IDLE;
        else          r_rx_state <= w_rx_next;
    end

`ifdef UART_AD_RX_PARITY_EN
    logic r_par;
    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n)                    r_par <= 1'b0;
        else if (r_rx_state == c_RX_IDLE) r_par <= 1'b0;
        else if (w_sample)               r_par <= r_par ^ r_rx_sync;
    end
    localparam logic [2:0] c_RX_AFTER_DATA = c_RX_PARITY;
    logic w_par_bad;
    assign w_par_bad = (r_rx_state == c_RX_PARITY) & w_bit_end & (r_rx_sync ^ r_par);
`else
    localparam logic [2:0] c_RX_AFTER_DATA = c_RX_STOP;
    logic w_par_bad;
    assign w_par_bad = 1'b0;
`endif

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            c_RX_IDLE:   if (w_rx_fall) w_rx_next = c_RX_START;
            c_RX_START:  if (w_half_end) w_rx_next = r_rx_sync ? c_RX_IDLE : c_RX_DATA;
            c_RX_DATA:   if (w_bit_end && r_bit_cnt == 3'd7) w_rx_next = c_RX_AFTER_DATA;
            c_RX_PARITY: if (w_bit_end) w_rx_next = w_par_bad ? c_RX_IDLE : c_RX_STOP;
            c_RX_STOP:   if (w_bit_end) w_rx_next = c_RX_IDLE;
            default:     w_rx_next = c_RX_IDLE;
        endcase
    end

    always_comb begin
        w_byte_stb = (r_rx_state == c_RX_STOP) & w_bit_end & r_rx_sync;
        w_rx_err   = ((r_rx_state == c_RX_STOP) & w_bit_end & ~r_rx_sync) | w_par_bad;
    end

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            r_os_cnt  <= 4'd0;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'd0;
        end else if (r_rx_state == c_RX_IDLE) begin
            r_os_cnt  <= 4'd0;
            r_bit_cnt <= 3'd0;
        end else if (r_tick) begin
            // START ends at mid-bit; restarting the count aligns later samples there.
            r_os_cnt <= (r_rx_state == c_RX_START && r_os_cnt == 4'd7) ? 4'd0 : r_os_cnt + 4'd1;
            if (w_sample) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                r_shift   <= {r_rx_sync, r_shift[7:1]};
            end
        end
    end

    // ---------------- frame parser FSM ----------------
    assign w_is_digit = (r_shift >= 8'd48) && (r_shift <= 8'd57);
    assign w_digit    = 4'(r_shift - 8'd48);
    assign w_chan     = 3'(r_shift - 8'd49);

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) r_p_state <= c_P_A;
        else          r_p_state <= w_p_next;
    end

    always_comb begin
        w_match = 1'b0;
        case (r_p_state)
            c_P_A:     w_match = (r_shift == 8'd65);
            c_P_D:     w_match = (r_shift == 8'd68);
            c_P_CH:    w_match = (r_shift >= 8'd49) && (r_shift <= 8'd56);
            c_P_COLON: w_match = (r_shift == 8'd58);
            c_P_SIGN:  w_match = (r_shift == 8'd43) || (r_shift == 8'd45);
            c_P_DOT:   w_match = (r_shift == 8'd46);
            c_P_V:     w_match = (r_shift == 8'd86);
            default:   w_match = w_is_digit;
        endcase
    end

    always_comb begin
        w_p_next = r_p_state;
        if (w_rx_err)
            w_p_next = c_P_A;
        else if (w_byte_stb) begin
            if (w_match)
                w_p_next = (r_p_state == c_P_V) ? c_P_A : r_p_state + 4'd1;
            else
                w_p_next = (r_shift == 8'd65) ? c_P_D : c_P_A;
        end
    end

    always_comb begin
        w_accept = w_byte_stb & w_match & (r_p_state == c_P_V);
        w_p_err  = w_rx_err | (w_byte_stb & ~w_match & (r_p_state != c_P_A));
    end

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            r_stg_num   <= 3'd0;
            r_stg_sig   <= 8'd43;
            r_stg_dec   <= 20'd0;
            ch_num      <= 3'd0;
            ch_sig      <= 8'd43;
            ch_dec      <= 20'd0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= w_accept;
            frame_err   <= w_p_err;
            if (w_byte_stb && w_match) begin
                case (r_p_state)
                    c_P_CH:   r_stg_num         <= w_chan;
                    c_P_SIGN: r_stg_sig         <= r_shift;
                    c_P_UNIT: r_stg_dec[19:16]  <= w_digit;
                    c_P_F0:   r_stg_dec[15:12]  <= w_digit;
                    c_P_F1:   r_stg_dec[11:8]   <= w_digit;
                    c_P_F2:   r_stg_dec[7:4]    <= w_digit;
                    c_P_F3:   r_stg_dec[3:0]    <= w_digit;
                    default:  ;
                endcase
            end
            if (w_accept) begin
                ch_num <= r_stg_num;
                ch_sig <= r_stg_sig;
                ch_dec <= r_stg_dec;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_ad_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_ad_rx
// Brief    : Scoreboard bench for uart_ad_rx; parity cases need UART_AD_RX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_ad_rx;

    localparam int c_DIV = 4;
    localparam int c_BIT = 16 * c_DIV;

    logic        clk50 = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx = 1'b1;
    logic [2:0]  ch_num;
    logic [7:0]  ch_sig;
    logic [19:0] ch_dec;
    logic        frame_valid, frame_err;

    typedef struct {
        logic        valid;
        logic [2:0]  num;
        logic [7:0]  sig;
        logic [19:0] dec;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;

    uart_ad_rx #(.BAUD_DIV(c_DIV)) dut (
        .clk50       (clk50),
        .reset_n     (reset_n),
        .rx          (rx),
        .ch_num      (ch_num),
        .ch_sig      (ch_sig),
        .ch_dec      (ch_dec),
        .frame_valid (frame_valid),
        .frame_err   (frame_err)
    );

    always #10 clk50 = ~clk50;

    task automatic chk(input string tag, input logic [19:0] got, input logic [19:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_ok(input logic [2:0] n, input logic [7:0] s, input logic [19:0] d);
        exp_t x;
        x.valid = 1'b1; x.num = n; x.sig = s; x.dec = d;
        exp_q.push_back(x);
    endtask

    task automatic push_err();
        exp_t x;
        x.valid = 1'b0; x.num = 3'd0; x.sig = 8'd0; x.dec = 20'd0;
        exp_q.push_back(x);
    endtask

    task automatic wait_bit();
        repeat (c_BIT) @(negedge clk50);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input logic par_good);
        rx = 1'b0;
        wait_bit();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_bit();
        end
`ifdef UART_AD_RX_PARITY_EN
        rx = par_good ? ^b : ~^b;
        wait_bit();
`else
        if (!par_good) $display("[TB] parity request ignored in 8N1 build");
`endif
        rx = stop;
        wait_bit();
        if (!stop) begin
            rx = 1'b1;
            wait_bit();
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1, 1'b1);
    endtask

    // Scoreboard: every output pulse must match the next queued expectation.
    always @(negedge clk50) begin
        if (frame_valid || frame_err) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {18'd0, frame_valid, frame_err}, 20'd0);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_kind", {19'd0, frame_valid}, {19'd0, e.valid});
                chk("pulse_excl", {19'd0, frame_valid & frame_err}, 20'd0);
                if (e.valid) begin
                    chk("ch_num", {17'd0, ch_num}, {17'd0, e.num});
                    chk("ch_sig", {12'd0, ch_sig}, {12'd0, e.sig});
                    chk("ch_dec", ch_dec, e.dec);
                end
            end
        end
    end

    initial begin
        repeat (5) @(negedge clk50);
        chk("rst_num", {17'd0, ch_num}, 20'd0);
        chk("rst_sig", {12'd0, ch_sig}, 20'd43);
        chk("rst_dec", ch_dec, 20'd0);
        chk("rst_valid", {19'd0, frame_valid}, 20'd0);
        chk("rst_err", {19'd0, frame_err}, 20'd0);
        reset_n = 1'b1;
        repeat (3 * c_BIT) @(negedge clk50);

        // Noise bytes before the first frame are silently dropped.
        send_str(" \r\n");
        push_ok(3'd2, 8'd45, 20'h12345);
        send_str("AD3:-1.2345V");

        push_err();
        send_str("AD9:");
        push_ok(3'd0, 8'd43, 20'h00007);
        send_str("AD1:+0.0007V");

        push_err();
        push_ok(3'd4, 8'd43, 20'h31416);
        send_str("AD2:+1.AD5:+3.1416V");

        // Stop bit low on '.' is a framing error; the rest of the frame is ignored.
        send_str("AD6:+7");
        push_err();
        send_byte(8'd46, 1'b0, 1'b1);
        send_str("8901V");
        repeat (2 * c_BIT) @(negedge clk50);
        chk("hold_num", {17'd0, ch_num}, 20'd4);
        chk("hold_sig", {12'd0, ch_sig}, 20'd43);
        chk("hold_dec", ch_dec, 20'h31416);

        // Reset during data bit 4 of 'V'.
        send_str("AD7:-9.9999");
        rx = 1'b0;
        wait_bit();
        for (int i = 0; i < 4; i++) begin
            rx = logic'(8'd86 >> i);
            wait_bit();
        end
        rx = 1'b0;
        repeat (c_BIT / 2) @(negedge clk50);
        reset_n = 1'b0;
        repeat (4) @(negedge clk50);
        rx = 1'b1;
        chk("mid_rst_num", {17'd0, ch_num}, 20'd0);
        chk("mid_rst_sig", {12'd0, ch_sig}, 20'd43);
        chk("mid_rst_dec", ch_dec, 20'd0);
        reset_n = 1'b1;
        repeat (2 * c_BIT) @(negedge clk50);
        push_ok(3'd7, 8'd43, 20'h50000);
        send_str("AD8:+5.0000V");

`ifdef UART_AD_RX_PARITY_EN
        send_str("AD1:-2.5000");
        push_err();
        send_byte(8'd86, 1'b1, 1'b0);
        push_ok(3'd0, 8'd45, 20'h25000);
        send_str("AD1:-2.5000V");
`endif

        repeat (2 * c_BIT) @(negedge clk50);
        chk("queue_empty", 20'(exp_q.size()), 20'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_ad_rx.md
UART_AD_RX -- requirements
Module: uart_ad_rx

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 325: clk50 cycles per 1/16-bit oversample tick (50 MHz, 9600 baud).
REQ-002 SHALL have port clk50, input, 1 bit: 50 MHz system clock; all logic on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-005 SHALL have port ch_num, output, 3 bits: channel index of the last good frame, 0 to 7 for AD1 to AD8.
REQ-006 SHALL have port ch_sig, output, 8 bits: ASCII sign character of the last good frame, '+' (43) or '-' (45).
REQ-007 SHALL have port ch_dec, output, 20 bits: five BCD digits of the last good frame, [19:16] units digit, [15:0] the four fraction digits.
REQ-008 SHALL have port frame_valid, output, 1 bit: one-cycle pulse when ch_num, ch_sig and ch_dec update.
REQ-009 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a framing error or a parse mismatch.

Function
REQ-010 SHALL pass rx through a two-flop synchronizer before any use; all timing below counts from the synchronized signal.
REQ-011 SHALL generate a one-cycle oversample tick every BAUD_DIV clk50 cycles from a free-running counter.
REQ-012 Byte receiver SHALL use states IDLE, START, DATA and STOP.
- IDLE goes to START when rx falls.
- START: after 8 ticks, if rx is still low go to DATA; if rx is high (glitch) return to IDLE with no error.
- DATA: sample one bit every 16 ticks, 8 bits, LSB first.
- STOP: sample 16 ticks after the last data bit; high gives a one-cycle byte strobe with the byte; low is a framing error, the byte is discarded and the FSM returns to IDLE.
REQ-013 Parser SHALL consume each byte strobe in sequence: 'A', 'D', digit '1'-'8', ':', sign ('+' or '-'), digit '0'-'9', '.', four digits '0'-'9', 'V'.
REQ-014 Parser SHALL convert digits to BCD by subtracting 48, and the channel digit to ch_num by subtracting 49.
REQ-015 Parser SHALL stage fields internally; outputs SHALL change only on acceptance of 'V'.
REQ-016 frame_valid SHALL pulse in the cycle after the 'V' byte strobe, together with the output update.
REQ-017 While waiting for 'A', parser SHALL silently ignore every byte other than 'A', including space, CR and LF.
REQ-018 A mismatched byte mid-frame SHALL pulse frame_err and return the parser to waiting for 'A'.
- If the mismatched byte is itself 'A', the parser SHALL treat it as the start of a new frame.
REQ-019 A framing error SHALL pulse frame_err and return the parser to waiting for 'A', regardless of parser state.
REQ-020 frame_valid and frame_err SHALL never assert in the same cycle.
REQ-021 ch_num, ch_sig and ch_dec SHALL hold their value between good frames.
REQ-022 Back-to-back bytes with zero idle time after the stop bit SHALL be received without loss.

Reset
REQ-023 On reset_n low, both FSMs SHALL go to IDLE / wait-'A' and all counters SHALL clear.
- Outputs: ch_num=0, ch_sig=43, ch_dec=0, frame_valid=0, frame_err=0.
- Synchronizer flops SHALL reset to 1.
REQ-024 A reset asserted mid-byte or mid-frame SHALL discard the partial data; after release, the first pulse on either output SHALL come from a complete new byte.

Configuration
REQ-025 With macro UART_AD_RX_PARITY_EN defined, an even parity bit SHALL be expected between data bit 7 and the stop bit.
- A parity mismatch is handled as a framing error (REQ-019).
REQ-026 Without UART_AD_RX_PARITY_EN, the frame SHALL be 8N1 and no parity logic SHALL be built.

Verification
REQ-027 Bench SHALL cover each scenario below, with BAUD_DIV=4 for simulation speed:
- "AD3:-1.2345V" at 8N1 -> one frame_valid; ch_num=2, ch_sig=45, ch_dec=20'h12345.
- "AD9:" then "AD1:+0.0007V" -> frame_err at '9'; then frame_valid with ch_num=0, ch_sig=43, ch_dec=20'h00007.
- "AD2:+1.AD5:+3.1416V" -> frame_err at 'A'; frame_valid with ch_num=4, ch_dec=20'h31416.
- Stop bit forced low on the '.' byte of a good frame -> frame_err; no frame_valid; outputs unchanged.
- reset_n pulsed low during data bit 4 of 'V' -> outputs at reset values; the next full good frame -> frame_valid.
- UART_AD_RX_PARITY_EN defined, 'V' sent with wrong parity -> frame_err; same frame with correct parity -> frame_valid.
